// File: rtl/cpu_types_pkg.sv
// Shared types for the fetch stage: word type, fetch FSM states, PC increment
// and the IF/ID entry record used by both the skid buffer and the IF/ID latch.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam word_t WBYTES = 32'd4;

  typedef struct packed {
    word_t instr;
    word_t pc;
    word_t npc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction side of the datapath-cache interface. The datapath (master)
// issues imemREN/imemaddr; the icache (slave) answers with ihit/imemload.
interface fetch_stage_if;
  import cpu_types_pkg::*;

  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;

  modport master (output imemREN, output imemaddr, input ihit, input imemload);
  modport slave  (input imemREN, input imemaddr, output ihit, output imemload);

endinterface

// File: rtl/fetch_buffer.sv
// One-entry skid register that captures a hit arriving while decode is stalled.
// Clear wins over load, load wins over drain.
module fetch_buffer
  import cpu_types_pkg::*;
(
  input  logic         CLK,
  input  logic         RST,
  input  logic         i_load,
  input  logic         i_drain,
  input  logic         i_clear,
  input  fetch_entry_t i_entry,
  output fetch_entry_t o_entry,
  output logic         o_full
);

  fetch_entry_t r_entry;
  logic         r_full;

  // NOTE: sequential state uses <= only, so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_entry <= '0;
      r_full  <= 1'b0;
    end else if (i_clear) begin
      r_full  <= 1'b0;
    end else if (i_load) begin
      r_entry <= i_entry;
      r_full  <= 1'b1;
    end else if (i_drain) begin
      r_full  <= 1'b0;
    end
  end

  assign o_entry = r_entry;
  assign o_full  = r_full;

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC, fetch FSM, skid buffer and IF/ID register.
// Define FETCH_PERF_COUNT_EN to add the fetch_count/stall_count counters.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic            CLK,
  input  logic            RST,
  fetch_stage_if.master   imem,
  input  logic            stall_IF,
  input  logic            flush_IF,
  input  logic            redirect,
  input  word_t           redirect_addr,
  input  logic            halt,
  output word_t           instr_ID,
  output word_t           imemaddr_ID,
  output word_t           next_addr_ID,
  output logic            valid_ID
`ifdef FETCH_PERF_COUNT_EN
  ,
  output word_t           fetch_count,
  output word_t           stall_count
`endif
);

  fetch_state_t r_state, w_next_state;
  word_t        r_pc, w_pc_plus4;
  fetch_entry_t r_ifid;
  logic         r_valid_id;
  fetch_entry_t w_buf_entry;
  logic         w_buf_full;

  logic w_halt_any, w_redirect, w_flush, w_fetching, w_hit;
  logic w_buf_load, w_buf_clear, w_direct_load, w_drain, w_bubble;
  logic w_unused_addr_bits;

  assign w_pc_plus4         = r_pc + WBYTES;
  assign w_unused_addr_bits = &{1'b0, redirect_addr[1:0]};

  // Control priority: halt > redirect > flush > stall.
  assign w_halt_any    = halt | (r_state == HALT);
  assign w_redirect    = redirect & ~w_halt_any;
  assign w_flush       = flush_IF & ~w_redirect & ~w_halt_any;
  assign w_fetching    = (r_state == FETCH) & ~w_halt_any & ~w_redirect;
  assign w_hit         = w_fetching & imem.ihit;
  assign w_buf_load    = w_hit & stall_IF;
  assign w_direct_load = w_hit & ~stall_IF & ~w_flush;
  assign w_drain       = (r_state == HOLD) & w_buf_full & ~stall_IF
                         & ~w_halt_any & ~w_redirect & ~w_flush;
  assign w_buf_clear   = w_halt_any | w_redirect | (w_flush & (r_state == HOLD));
  assign w_bubble      = w_halt_any | w_redirect | w_flush
                         | (w_fetching & ~imem.ihit & ~stall_IF);

  fetch_buffer u_buffer (
    .CLK     (CLK),
    .RST     (RST),
    .i_load  (w_buf_load),
    .i_drain (w_drain),
    .i_clear (w_buf_clear),
    .i_entry ('{instr: imem.imemload, pc: r_pc, npc: w_pc_plus4}),
    .o_entry (w_buf_entry),
    .o_full  (w_buf_full)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: default first so every path assigns w_next_state and no latch is inferred.
    w_next_state = r_state;
    if (w_halt_any) begin
      w_next_state = HALT;
    end else if (w_redirect) begin
      w_next_state = FETCH;
    end else begin
      unique case (r_state)
        IDLE:    w_next_state = FETCH;
        FETCH:   if (imem.ihit && stall_IF) w_next_state = HOLD;
        HOLD:    if (w_flush || !stall_IF)  w_next_state = FETCH;
        HALT:    w_next_state = HALT;
        default: w_next_state = IDLE;
      endcase
    end
  end

  // Request lines depend on registered state only, never on ihit.
  always_comb begin
    imem.imemREN  = (r_state == FETCH);
    imem.imemaddr = r_pc;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pc <= PC_INIT;
    end else if (w_redirect) begin
      r_pc <= {redirect_addr[31:2], 2'b00};
    end else if (w_hit) begin
      r_pc <= w_pc_plus4;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ifid     <= '0;
      r_valid_id <= 1'b0;
    end else if (w_direct_load) begin
      r_ifid     <= '{instr: imem.imemload, pc: r_pc, npc: w_pc_plus4};
      r_valid_id <= 1'b1;
    end else if (w_drain) begin
      r_ifid     <= w_buf_entry;
      r_valid_id <= 1'b1;
    end else if (w_bubble) begin
      r_ifid.instr <= '0;
      r_valid_id   <= 1'b0;
    end
  end

  assign instr_ID     = r_ifid.instr;
  assign imemaddr_ID  = r_ifid.pc;
  assign next_addr_ID = r_ifid.npc;
  assign valid_ID     = r_valid_id;

`ifdef FETCH_PERF_COUNT_EN
  word_t r_fetch_count, r_stall_count;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_fetch_count <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_direct_load || w_drain)         r_fetch_count <= r_fetch_count + 32'd1;
      if (stall_IF && (r_state != HALT))    r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign fetch_count = r_fetch_count;
  assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected IF/ID entries are queued when a
// fetch is stimulated and popped when the IF/ID register should show them.
module tb_fetch_stage;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  RST;
  logic  stall_IF, flush_IF, redirect, halt;
  word_t redirect_addr;
  word_t instr_ID, imemaddr_ID, next_addr_ID;
  logic  valid_ID;
`ifdef FETCH_PERF_COUNT_EN
  word_t fetch_count, stall_count;
`endif

  int total = 0;
  int bad   = 0;
  fetch_entry_t sb[$];

  fetch_stage_if bus ();

  fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .imem          (bus),
    .stall_IF      (stall_IF),
    .flush_IF      (flush_IF),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .halt          (halt),
    .instr_ID      (instr_ID),
    .imemaddr_ID   (imemaddr_ID),
    .next_addr_ID  (next_addr_ID),
    .valid_ID      (valid_ID)
`ifdef FETCH_PERF_COUNT_EN
    ,
    .fetch_count   (fetch_count),
    .stall_count   (stall_count)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic word_t mem_word(word_t a);
    return a ^ 32'h1234_5678;
  endfunction

  assign bus.imemload = mem_word(bus.imemaddr);

  task automatic chk(string tag, word_t obs, word_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(string tag, logic obs, logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic set_in(bit hit, bit st, bit fl, bit rd, word_t ra, bit hl);
    bus.ihit      = hit;
    stall_IF      = st;
    flush_IF      = fl;
    redirect      = rd;
    redirect_addr = ra;
    halt          = hl;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_fetch(word_t pc);
    sb.push_back('{instr: mem_word(pc), pc: pc, npc: pc + WBYTES});
  endtask

  task automatic pop_check(string tag);
    fetch_entry_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_instr"}, instr_ID, e.instr);
      chk({tag, "_pc"}, imemaddr_ID, e.pc);
      chk({tag, "_npc"}, next_addr_ID, e.npc);
      chk1({tag, "_valid"}, valid_ID, 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    set_in(0, 0, 0, 0, '0, 0);
    RST = 1'b1;
    repeat (2) tick();
    chk1("rst_ren", bus.imemREN, 1'b0);
    chk("rst_addr", bus.imemaddr, 32'h0);
    chk1("rst_valid", valid_ID, 1'b0);
    chk("rst_instr", instr_ID, 32'h0);
    chk("rst_pc_id", imemaddr_ID, 32'h0);
    chk("rst_npc_id", next_addr_ID, 32'h0);
`ifdef FETCH_PERF_COUNT_EN
    chk("rst_fetch_count", fetch_count, 32'h0);
`endif
    RST = 1'b0;
    chk1("idle_ren", bus.imemREN, 1'b0);
    tick();
    chk1("fetch_ren", bus.imemREN, 1'b1);

    // Streaming fetches 0, 4.
    set_in(1, 0, 0, 0, '0, 0);
    for (int i = 0; i < 2; i++) begin
      expect_fetch(i * 4);
      chk("stream_addr", bus.imemaddr, i * 4);
      tick();
      pop_check("stream");
    end

    // Hit at PC=8 while stalled for three cycles.
    set_in(1, 1, 0, 0, '0, 0);
    chk("stall_addr", bus.imemaddr, 32'h8);
    tick();
    chk1("hold_ren", bus.imemREN, 1'b0);
    chk("hold_ifid", imemaddr_ID, 32'h4);
    chk("hold_addr", bus.imemaddr, 32'hC);
    repeat (2) begin
      tick();
      chk1("hold2_ren", bus.imemREN, 1'b0);
      chk("hold2_ifid", imemaddr_ID, 32'h4);
    end
    set_in(0, 0, 0, 0, '0, 0);
    expect_fetch(32'h8);
    tick();
    pop_check("release");
    chk1("release_ren", bus.imemREN, 1'b1);
    chk("release_addr", bus.imemaddr, 32'hC);

    // Redirect without a hit, then a redirect that drops a same-cycle hit.
    set_in(0, 0, 0, 1, 32'h0000_0103, 0);
    tick();
    chk("redir_addr", bus.imemaddr, 32'h100);
    chk1("redir_valid", valid_ID, 1'b0);
    chk("redir_instr", instr_ID, 32'h0);
    set_in(1, 0, 0, 1, 32'h0000_0200, 0);
    tick();
    chk("redir_hit_addr", bus.imemaddr, 32'h200);
    chk1("redir_hit_valid", valid_ID, 1'b0);

    // Redirect plus stall while holding a buffered hit.
    set_in(1, 1, 0, 0, '0, 0);
    tick();
    chk1("hold_b_ren", bus.imemREN, 1'b0);
    chk("hold_b_addr", bus.imemaddr, 32'h204);
    set_in(0, 1, 0, 1, 32'h0000_0300, 0);
    tick();
    chk1("hold_redir_ren", bus.imemREN, 1'b1);
    chk("hold_redir_addr", bus.imemaddr, 32'h300);
    chk1("hold_redir_valid", valid_ID, 1'b0);
    set_in(0, 0, 0, 0, '0, 0);
    tick();
    chk1("buf_discard_valid", valid_ID, 1'b0);
    chk("buf_discard_addr", bus.imemaddr, 32'h300);

    // Flush in FETCH with a hit, then flush in HOLD.
    set_in(1, 0, 1, 0, '0, 0);
    tick();
    chk1("flush_valid", valid_ID, 1'b0);
    chk("flush_instr", instr_ID, 32'h0);
    chk("flush_addr", bus.imemaddr, 32'h304);
    set_in(1, 1, 0, 0, '0, 0);
    tick();
    chk1("flush_hold_ren", bus.imemREN, 1'b0);
    chk("flush_hold_addr", bus.imemaddr, 32'h308);
    set_in(0, 1, 1, 0, '0, 0);
    tick();
    chk1("flush_hold_exit_ren", bus.imemREN, 1'b1);
    chk1("flush_hold_valid", valid_ID, 1'b0);
    chk("flush_hold_pc", bus.imemaddr, 32'h308);
    set_in(0, 0, 0, 0, '0, 0);
    tick();
    chk1("flush_hold_gone", valid_ID, 1'b0);

    // PC wrap from the top of the address space.
    set_in(0, 0, 0, 1, 32'hFFFF_FFFC, 0);
    tick();
    chk("wrap_start", bus.imemaddr, 32'hFFFF_FFFC);
    set_in(1, 0, 0, 0, '0, 0);
    expect_fetch(32'hFFFF_FFFC);
    tick();
    pop_check("wrap");
    chk("wrap_addr", bus.imemaddr, 32'h0);

    // Back-to-back throughput after the wrap.
    for (int i = 0; i < 3; i++) begin
      expect_fetch(i * 4);
      chk("tput_addr", bus.imemaddr, i * 4);
      tick();
      pop_check("tput");
    end

    // Halt, then show that redirect/hit/stall are ignored.
    set_in(1, 0, 0, 0, '0, 1);
    tick();
    chk1("halt_ren", bus.imemREN, 1'b0);
    chk1("halt_valid", valid_ID, 1'b0);
    chk("halt_addr", bus.imemaddr, 32'hC);
    set_in(1, 1, 0, 1, 32'h0000_0040, 0);
    repeat (3) begin
      tick();
      chk1("halted_ren", bus.imemREN, 1'b0);
      chk("halted_addr", bus.imemaddr, 32'hC);
      chk1("halted_valid", valid_ID, 1'b0);
    end

    // Asynchronous reset out of HALT.
    set_in(0, 0, 0, 0, '0, 0);
    #2 RST = 1'b1;
    #1;
    chk("async_rst_addr", bus.imemaddr, 32'h0);
    chk1("async_rst_ren", bus.imemREN, 1'b0);
    tick();
    RST = 1'b0;
    tick();
    chk1("post_rst_ren", bus.imemREN, 1'b1);
    chk("post_rst_addr", bus.imemaddr, 32'h0);

    chk("sb_empty", sb.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
